// File: rtl/cc_stack_unit.sv
// Condition-code unit for the SLC-3 datapath: N/Z/P generation, BR evaluation,
// and a LIFO of saved codes for interrupt/trap entry and exit with sticky errors.
module cc_stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     LD,
  input  logic [WIDTH-1:0]         in,
  input  logic                     unsigned_mode,
  input  logic                     push,
  input  logic                     pop,
  input  logic [2:0]               br_mask,
  input  logic                     err_clr,
  output logic [2:0]               nzp,
  output logic                     cc_valid,
  output logic                     br_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf_err,
  output logic                     unf_err
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0]    r_stack [DEPTH];
  logic [AW:0]   r_level;
  logic [2:0]    r_nzp;
  logic          r_cc_valid;
  logic          r_ovf_err;
  logic          r_unf_err;

  logic [2:0]    w_code;
  logic          w_full;
  logic          w_empty;
  logic          w_push_only;
  logic          w_pop_only;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_code = 3'b001;
    if (in == '0)
      w_code = 3'b010;
    else if (!unsigned_mode && in[WIDTH-1])
      w_code = 3'b100;
  end

  assign w_full      = (r_level == (AW+1)'(DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_push_only = push & ~pop;
  assign w_pop_only  = pop & ~push;
  assign w_push_ok   = w_push_only & ~w_full;
  assign w_pop_ok    = w_pop_only & ~w_empty;
  assign w_wr_idx    = r_level[AW-1:0];
  // When full the low bits wrap to 0, so subtracting one still lands on DEPTH-1.
  assign w_rd_idx    = r_level[AW-1:0] - AW'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_level    <= '0;
      r_nzp      <= 3'b000;
      r_cc_valid <= 1'b0;
      r_ovf_err  <= 1'b0;
      r_unf_err  <= 1'b0;
    end else begin
      if (w_pop_ok) begin
        r_nzp      <= r_stack[w_rd_idx];
        r_level    <= r_level - (AW+1)'(1);
        r_cc_valid <= 1'b1;
      end else begin
        if (w_push_ok)
          r_level <= r_level + (AW+1)'(1);
        if (LD) begin
          r_nzp      <= w_code;
          r_cc_valid <= 1'b1;
        end
      end
      // A new error outranks a same-cycle clear.
      r_ovf_err <= (w_push_only & w_full)  | (r_ovf_err & ~err_clr);
      r_unf_err <= (w_pop_only  & w_empty) | (r_unf_err & ~err_clr);
    end
  end

  // NOTE: stack storage is deliberately not reset; entries above the top pointer are never read.
  always_ff @(posedge Clk) begin
    if (!Reset && w_push_ok)
      r_stack[w_wr_idx] <= r_cc_valid ? r_nzp : 3'b000;
  end

  assign nzp      = r_nzp;
  assign cc_valid = r_cc_valid;
  assign br_en    = r_cc_valid & |(br_mask & r_nzp);
  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_level;
  assign ovf_err  = r_ovf_err;
  assign unf_err  = r_unf_err;

endmodule
